// File: rtl/tri_rasterizer.sv
// rtl/tri_rasterizer.sv - bounding-box scan triangle rasterizer with edge-function coverage test
module tri_rasterizer #(
    parameter int H_RES = 1280,
    parameter int V_RES = 720
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic signed [11:0] vx0_in,
    input  logic signed [11:0] vy0_in,
    input  logic signed [11:0] vx1_in,
    input  logic signed [11:0] vy1_in,
    input  logic signed [11:0] vx2_in,
    input  logic signed [11:0] vy2_in,
    input  logic               tri_valid_in,
    output logic               tri_ready_out,
    output logic [10:0]        px_out,
    output logic [9:0]         py_out,
    output logic               pixel_valid_out,
    input  logic               pixel_ready_in,
    output logic               tri_done_out,
    output logic               busy_out
);

    localparam logic signed [12:0] X_LIM = 13'(H_RES - 1);
    localparam logic signed [12:0] Y_LIM = 13'(V_RES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

    state_t state, next_state;

    logic signed [11:0] x0, y0, x1, y1, x2, y2;
    logic [10:0] bx_min, bx_max, sx;
    logic [9:0]  by_min, by_max, sy;
    logic        area_pos;
    logic        scan_end;

    // (xb-xa)*(qy-ya) - (yb-ya)*(qx-xa), kept exact: 13-bit deltas, 26-bit products, 27-bit sum
    function automatic logic signed [26:0] edge_fn(
        input logic signed [11:0] xa,
        input logic signed [11:0] ya,
        input logic signed [11:0] xb,
        input logic signed [11:0] yb,
        input logic signed [12:0] qx,
        input logic signed [12:0] qy
    );
        logic signed [12:0] dx, dy, ox, oy;
        logic signed [25:0] p0, p1;
        dx = {xb[11], xb} - {xa[11], xa};
        dy = {yb[11], yb} - {ya[11], ya};
        ox = qx - {xa[11], xa};
        oy = qy - {ya[11], ya};
        p0 = 26'(dx) * 26'(oy);
        p1 = 26'(dy) * 26'(ox);
        return 27'(p0) - 27'(p1);
    endfunction

    function automatic logic signed [12:0] min3(
        input logic signed [11:0] a,
        input logic signed [11:0] b,
        input logic signed [11:0] c
    );
        logic signed [11:0] m;
        m = (a < b) ? a : b;
        m = (c < m) ? c : m;
        return {m[11], m};
    endfunction

    function automatic logic signed [12:0] max3(
        input logic signed [11:0] a,
        input logic signed [11:0] b,
        input logic signed [11:0] c
    );
        logic signed [11:0] m;
        m = (a > b) ? a : b;
        m = (c > m) ? c : m;
        return {m[11], m};
    endfunction

    logic signed [12:0] raw_xmin, raw_xmax, raw_ymin, raw_ymax;
    logic signed [12:0] xlo, xhi, ylo, yhi;
    logic signed [26:0] area;
    logic               area_zero, bbox_empty;

    always_comb begin
        raw_xmin = min3(x0, x1, x2);
        raw_xmax = max3(x0, x1, x2);
        raw_ymin = min3(y0, y1, y2);
        raw_ymax = max3(y0, y1, y2);
        xlo = raw_xmin[12] ? 13'sd0 : raw_xmin;
        ylo = raw_ymin[12] ? 13'sd0 : raw_ymin;
        xhi = (raw_xmax > X_LIM) ? X_LIM : raw_xmax;
        yhi = (raw_ymax > Y_LIM) ? Y_LIM : raw_ymax;
        bbox_empty = (xlo > xhi) || (ylo > yhi);
        area = edge_fn(x0, y0, x1, y1, {x2[11], x2}, {y2[11], y2});
        area_zero = (area == '0);
    end

    logic signed [12:0] cur_x, cur_y;
    logic signed [26:0] e0, e1, e2;
    logic               covered;
    logic               advance;
    logic               row_end, last_row;

    always_comb begin
        cur_x = {2'b00, sx};
        cur_y = {3'b000, sy};
        e0 = edge_fn(x0, y0, x1, y1, cur_x, cur_y);
        e1 = edge_fn(x1, y1, x2, y2, cur_x, cur_y);
        e2 = edge_fn(x2, y2, x0, y0, cur_x, cur_y);
        // Inclusive on all edges; winding chooses which sign counts as inside
        if (area_pos) begin
            covered = !e0[26] && !e1[26] && !e2[26];
        end else begin
            covered = (e0[26] || e0 == '0) && (e1[26] || e1 == '0) && (e2[26] || e2 == '0);
        end
        advance  = (state == SCAN) && !scan_end && (!pixel_valid_out || pixel_ready_in);
        row_end  = (sx == bx_max);
        last_row = (sy == by_max);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (tri_valid_in) next_state = SETUP;
            SETUP: next_state = (area_zero || bbox_empty) ? DONE : SCAN;
            SCAN:  if (scan_end && (!pixel_valid_out || pixel_ready_in)) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign tri_ready_out = (state == IDLE);
    assign busy_out      = (state != IDLE);
    assign tri_done_out  = (state == DONE);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            x0 <= '0;
            y0 <= '0;
            x1 <= '0;
            y1 <= '0;
            x2 <= '0;
            y2 <= '0;
        end else if (state == IDLE && tri_valid_in) begin
            x0 <= vx0_in;
            y0 <= vy0_in;
            x1 <= vx1_in;
            y1 <= vy1_in;
            x2 <= vx2_in;
            y2 <= vy2_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bx_min   <= '0;
            bx_max   <= '0;
            by_min   <= '0;
            by_max   <= '0;
            sx       <= '0;
            sy       <= '0;
            area_pos <= 1'b0;
            scan_end <= 1'b0;
        end else if (state == SETUP) begin
            bx_min   <= xlo[10:0];
            bx_max   <= xhi[10:0];
            by_min   <= ylo[9:0];
            by_max   <= yhi[9:0];
            sx       <= xlo[10:0];
            sy       <= ylo[9:0];
            area_pos <= !area[26];
            scan_end <= 1'b0;
        end else if (advance) begin
            if (row_end) begin
                sx <= bx_min;
                if (last_row) begin
                    scan_end <= 1'b1;
                end else begin
                    sy <= sy + 10'd1;
                end
            end else begin
                sx <= sx + 11'd1;
            end
        end
    end

    // Output register: loads only on an evaluation slot, drains when accepted
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pixel_valid_out <= 1'b0;
            px_out          <= '0;
            py_out          <= '0;
        end else if (advance) begin
            pixel_valid_out <= covered;
            if (covered) begin
                px_out <= sx;
                py_out <= sy;
            end
        end else if (pixel_ready_in) begin
            pixel_valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tri_rasterizer.sv
// tb/tb_tri_rasterizer.sv - randomized self-checking bench for tri_rasterizer
`timescale 1ns/1ps
module tb_tri_rasterizer;

    localparam int H = 1280;
    localparam int V = 720;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [11:0] vx0, vy0, vx1, vy1, vx2, vy2;
    logic tri_valid = 1'b0;
    logic tri_ready;
    logic [10:0] px;
    logic [9:0] py;
    logic pixel_valid;
    logic pixel_ready = 1'b1;
    logic tri_done;
    logic busy;

    tri_rasterizer #(.H_RES(H), .V_RES(V)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .vx0_in(vx0),
        .vy0_in(vy0),
        .vx1_in(vx1),
        .vy1_in(vy1),
        .vx2_in(vx2),
        .vy2_in(vy2),
        .tri_valid_in(tri_valid),
        .tri_ready_out(tri_ready),
        .px_out(px),
        .py_out(py),
        .pixel_valid_out(pixel_valid),
        .pixel_ready_in(pixel_ready),
        .tri_done_out(tri_done),
        .busy_out(busy)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    int exp_x[$], exp_y[$], got_x[$], got_y[$];
    int done_pulses, hold_viol, held_cnt, end_cycle;
    bit timeout;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference: walk the clipped box row by row and keep pixels on the inside of all three edges
    task automatic model_tri(input int ax, input int ay, input int bx, input int by,
                             input int cx, input int cy);
        int area, xlo, xhi, ylo, yhi, e0, e1, e2;
        bit cov;
        exp_x.delete();
        exp_y.delete();
        area = (bx - ax) * (cy - ay) - (by - ay) * (cx - ax);
        if (area == 0) return;
        xlo = imax(imin(ax, imin(bx, cx)), 0);
        xhi = imin(imax(ax, imax(bx, cx)), H - 1);
        ylo = imax(imin(ay, imin(by, cy)), 0);
        yhi = imin(imax(ay, imax(by, cy)), V - 1);
        for (int y = ylo; y <= yhi; y++) begin
            for (int x = xlo; x <= xhi; x++) begin
                e0 = (bx - ax) * (y - ay) - (by - ay) * (x - ax);
                e1 = (cx - bx) * (y - by) - (cy - by) * (x - bx);
                e2 = (ax - cx) * (y - cy) - (ay - cy) * (x - cx);
                cov = (area > 0) ? (e0 >= 0 && e1 >= 0 && e2 >= 0)
                                 : (e0 <= 0 && e1 <= 0 && e2 <= 0);
                if (cov) begin
                    exp_x.push_back(x);
                    exp_y.push_back(y);
                end
            end
        end
    endtask

    // mode 0: always ready, 1: random ready, 2: stall the second pixel for 5 cycles
    task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy, input int mode, input int budget);
        int cyc, low, prev_x, prev_y;
        bit prev_stall, rdy, finished;
        got_x.delete();
        got_y.delete();
        done_pulses = 0;
        hold_viol = 0;
        held_cnt = 0;
        end_cycle = 0;
        timeout = 0;
        finished = 0;
        prev_stall = 0;
        prev_x = 0;
        prev_y = 0;
        low = 0;
        cyc = 0;
        @(negedge clk);
        vx0 = 12'(ax); vy0 = 12'(ay);
        vx1 = 12'(bx); vy1 = 12'(by);
        vx2 = 12'(cx); vy2 = 12'(cy);
        tri_valid = 1'b1;
        pixel_ready = 1'b1;
        @(posedge clk);
        #1;
        tri_valid = 1'b0;
        vx0 = 12'($urandom); vy0 = 12'($urandom);
        vx1 = 12'($urandom); vy1 = 12'($urandom);
        vx2 = 12'($urandom); vy2 = 12'($urandom);
        while (cyc < budget && !finished) begin
            @(negedge clk);
            cyc++;
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    rdy = !(pixel_valid && got_x.size() == 1 && low < 5);
                    if (!rdy) low++;
                end
            endcase
            pixel_ready = rdy;
            if (prev_stall && (!pixel_valid || int'(px) != prev_x || int'(py) != prev_y))
                hold_viol++;
            if (pixel_valid && !rdy && px == 11'd1 && py == 10'd0) held_cnt++;
            prev_stall = pixel_valid && !rdy;
            prev_x = int'(px);
            prev_y = int'(py);
            if (pixel_valid && rdy) begin
                got_x.push_back(int'(px));
                got_y.push_back(int'(py));
            end
            if (tri_done) begin
                done_pulses++;
                if (end_cycle == 0) end_cycle = cyc;
            end else if (done_pulses > 0) begin
                finished = 1;
            end
        end
        timeout = !finished;
        pixel_ready = 1'b1;
    endtask

    function automatic int count_order_errors();
        int n;
        n = 0;
        for (int i = 0; i < imin(got_x.size(), exp_x.size()); i++)
            if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) n++;
        return n;
    endfunction

    task automatic check_run(input string name);
        int oe;
        oe = count_order_errors();
        tests_run++;
        if (timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_timeout: no done pulse within budget (got %0d pixels)", name, got_x.size());
        end
        tests_run++;
        if (got_x.size() !== exp_x.size() || oe !== 0) begin
            tests_failed++;
            $display("FAIL %s_pixels: got %0d pixels with %0d out of order, expected %0d",
                     name, got_x.size(), oe, exp_x.size());
        end
        tests_run++;
        if (done_pulses !== 1) begin
            tests_failed++;
            $display("FAIL %s_done: %0d done cycles, expected 1", name, done_pulses);
        end
        tests_run++;
        if (hold_viol !== 0) begin
            tests_failed++;
            $display("FAIL %s_hold: %0d stalled pixels changed, expected 0", name, hold_viol);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({tri_ready, pixel_valid, tri_done, busy} !== 4'b1000 || px !== 11'd0 || py !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ready/valid/done/busy=%b px=%0d py=%0d, expected 1000 0 0",
                     {tri_ready, pixel_valid, tri_done, busy}, px, py);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (tri_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: ready=%b busy=%b, expected 1 0", tri_ready, busy);
        end
    endtask

    task automatic test_basic();
        model_tri(0, 0, 3, 0, 0, 3);
        run_tri(0, 0, 3, 0, 0, 3, 0, 200);
        check_run("basic");
        tests_run++;
        if (got_x.size() !== 10 || (got_x.size() >= 5 && (got_x[4] !== 0 || got_y[4] !== 1))) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d pixels, expected 10 with fifth at (0,1)", got_x.size());
        end
    endtask

    task automatic test_reversed();
        model_tri(0, 0, 3, 0, 0, 3);
        run_tri(0, 0, 0, 3, 3, 0, 0, 200);
        check_run("reversed");
    endtask

    task automatic test_collinear();
        model_tri(0, 0, 2, 2, 4, 4);
        run_tri(0, 0, 2, 2, 4, 4, 0, 50);
        check_run("collinear");
        tests_run++;
        if (end_cycle > 3 || tri_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL collinear_latency: done at cycle %0d ready=%b, expected <=3 and 1",
                     end_cycle, tri_ready);
        end
    endtask

    task automatic test_clip();
        int bad;
        model_tri(-5, -5, 10, -5, -5, 10);
        run_tri(-5, -5, 10, -5, -5, 10, 1, 2000);
        check_run("clip");
        bad = 0;
        foreach (got_x[i]) if (got_x[i] + got_y[i] > 5) bad++;
        tests_run++;
        if (got_x.size() !== 21 || bad !== 0) begin
            tests_failed++;
            $display("FAIL clip_count: got %0d pixels, %0d beyond x+y<=5, expected 21 and 0",
                     got_x.size(), bad);
        end
    endtask

    task automatic test_screen_edge();
        model_tri(1270, 700, 1300, 705, 1275, 740);
        run_tri(1270, 700, 1300, 705, 1275, 740, 1, 4000);
        check_run("edge");
    endtask

    task automatic test_backpressure();
        model_tri(0, 0, 3, 0, 0, 3);
        run_tri(0, 0, 3, 0, 0, 3, 2, 200);
        check_run("backpressure");
        tests_run++;
        if (held_cnt !== 5) begin
            tests_failed++;
            $display("FAIL backpressure_held: (1,0) stalled %0d cycles, expected 5", held_cnt);
        end
    endtask

    task automatic test_reset_mid_scan();
        int accepted, cyc, stray;
        accepted = 0;
        cyc = 0;
        stray = 0;
        @(negedge clk);
        vx0 = 12'sd0; vy0 = 12'sd0;
        vx1 = 12'sd3; vy1 = 12'sd0;
        vx2 = 12'sd0; vy2 = 12'sd3;
        tri_valid = 1'b1;
        pixel_ready = 1'b1;
        @(posedge clk);
        #1;
        tri_valid = 1'b0;
        while (accepted < 4 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (pixel_valid) accepted++;
        end
        tests_run++;
        if (accepted !== 4) begin
            tests_failed++;
            $display("FAIL midreset_reach: %0d pixels before budget, expected 4", accepted);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (pixel_valid !== 1'b0 || busy !== 1'b0 || tri_done !== 1'b0 || px !== 11'd0 || py !== 10'd0) begin
            tests_failed++;
            $display("FAIL midreset_async: valid=%b busy=%b done=%b px=%0d py=%0d, expected 0 0 0 0 0",
                     pixel_valid, busy, tri_done, px, py);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (tri_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_ready: ready=%b, expected 1", tri_ready);
        end
        repeat (20) begin
            @(negedge clk);
            if (pixel_valid || busy) stray++;
        end
        tests_run++;
        if (stray !== 0) begin
            tests_failed++;
            $display("FAIL midreset_stray: %0d cycles with pixel or busy after reset, expected 0", stray);
        end
    endtask

    task automatic test_random();
        int c[6];
        for (int t = 0; t < 12; t++) begin
            foreach (c[i]) c[i] = int'($urandom_range(0, 50)) - 10;
            model_tri(c[0], c[1], c[2], c[3], c[4], c[5]);
            run_tri(c[0], c[1], c[2], c[3], c[4], c[5], 1, 8000);
            check_run($sformatf("random%0d", t));
        end
    endtask

    initial begin
        vx0 = '0; vy0 = '0; vx1 = '0; vy1 = '0; vx2 = '0; vy2 = '0;
        test_reset();
        test_basic();
        test_reversed();
        test_collinear();
        test_clip();
        test_screen_edge();
        test_backpressure();
        test_reset_mid_scan();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tri_rasterizer.md
TRI_RASTERIZER -- requirements
Module: tri_rasterizer

Interface
REQ-001 SHALL have parameter H_RES, default 1280, screen width in pixels.
REQ-002 SHALL have parameter V_RES, default 720, screen height in pixels.
REQ-003 SHALL have port clk_in, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_in, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have ports vx0_in, vy0_in, vx1_in, vy1_in, vx2_in, vy2_in, input, 12 each, signed screen-space integer vertex coordinates from the projection stage.
REQ-006 SHALL have port tri_valid_in, input, 1, vertex set valid.
REQ-007 SHALL have port tri_ready_out, output, 1, block accepts a triangle.
REQ-008 SHALL have port px_out, output, 11, pixel x.
REQ-009 SHALL have port py_out, output, 10, pixel y.
REQ-010 SHALL have port pixel_valid_out, output, 1, px_out/py_out hold a covered pixel.
REQ-011 SHALL have port pixel_ready_in, input, 1, downstream accepts pixel.
REQ-012 SHALL have port tri_done_out, output, 1, one-cycle pulse at end of triangle.
REQ-013 SHALL have port busy_out, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, SETUP, SCAN, DONE.
REQ-015 IDLE: tri_ready_out=1; on tri_valid_in=1, latch all six coordinates, go to SETUP; tri_valid_in ignored in all other states.
REQ-016 SETUP (1 cycle): bounding box = min/max of vertex coordinates, clamped to x in [0,H_RES-1] and y in [0,V_RES-1]; signed area A = (x1-x0)*(y2-y0) - (y1-y0)*(x2-x0); scan pointer = (xmin,ymin).
REQ-017 SETUP: if A==0, or clamped xmin>xmax, or clamped ymin>ymax, SHALL go to DONE emitting no pixels; else go to SCAN.
REQ-018 Edge function E_ab(p) = (xb-xa)*(py-ya) - (yb-ya)*(px-xa) SHALL be evaluated for edges 0->1, 1->2, 2->0 at full precision (13-bit differences, 26-bit products, 27-bit signed sum); no truncation.
REQ-019 Pixel SHALL be covered iff all three E >= 0 when A>0, or all three E <= 0 when A<0 (edges inclusive, no top-left rule).
REQ-020 SCAN SHALL visit bbox pixels in raster order, x fastest, evaluating one pixel per cycle while the output register is empty or being accepted.
REQ-021 A covered pixel SHALL appear on px_out/py_out with pixel_valid_out=1 one cycle after its evaluation.
REQ-022 While pixel_valid_out=1 and pixel_ready_in=0, px_out, py_out and pixel_valid_out SHALL hold and the scan pointer SHALL not advance; no pixel dropped or duplicated.
REQ-023 Uncovered pixels SHALL produce no output; pixel_valid_out=0 when the register holds nothing.
REQ-024 After (xmax,ymax) is evaluated and any resulting pixel accepted, SHALL enter DONE.
REQ-025 DONE (1 cycle): tri_done_out=1, then IDLE; next triangle accepted the following cycle.
REQ-026 Vertex values SHALL be sampled only at the IDLE handshake; later input changes SHALL not affect the triangle in flight.

Reset
REQ-027 rst_in=1 SHALL asynchronously force IDLE, pixel_valid_out=0, tri_done_out=0, busy_out=0, px_out=0, py_out=0, tri_ready_out=1 (after release), from any state including mid-SCAN.
REQ-028 No pixel of a triangle interrupted by reset SHALL be emitted after reset release.

Verification
REQ-029 (0,0),(3,0),(0,3), pixel_ready_in=1 -> exactly 10 pixels (x+y<=3), raster order starting (0,0),(1,0),(2,0),(3,0),(0,1); one tri_done_out pulse.
REQ-030 Reversed winding (0,0),(0,3),(3,0) -> same 10 pixels, same order.
REQ-031 Collinear (0,0),(2,2),(4,4) -> zero pixels, tri_done_out pulse, back to IDLE within 3 cycles of handshake.
REQ-032 Clipping (-5,-5),(10,-5),(-5,10) -> exactly 21 pixels, all x,y>=0 with x+y<=5.
REQ-033 Backpressure: REQ-029 triangle with pixel_ready_in low 5 cycles on 2nd pixel -> (1,0) held stable 5 cycles, total still 10 pixels, none duplicated.
REQ-034 Assert rst_in during SCAN of REQ-029 after 4th pixel -> pixel_valid_out=0 immediately, no further pixels, tri_ready_out=1 after release.
